rx_ctrl: RTL and testbench
==========================

Name: rx_ctrl

Overview:
- RIFFA channel receive-side controller. It is the host-to-FPGA counterpart of the channel transmit controllers.
- Detects a host transfer on the CHNL_RX interface, acknowledges it, and pulls 64-bit beats with DATA_REN.
- Forwards beats through a one-stage registered valid/ready stream to downstream logic.
- Reports completion, word count and short/timeout status per transaction.

Parameters:
- TIMEOUT_CYCLES, 1024: idle cycles in RECV before abort. Used only when RX_TIMEOUT_EN is defined.
- CNT_W, 32: width of the beat and word counters.

Ports:
- CLK  in  1  system clock; rising edge.
- RST  in  1  reset; synchronous, active-high.
- CHNL_RX_CLK  out  1  driven = CLK.
- CHNL_RX  in  1  host transfer pending.
- CHNL_RX_ACK  out  1  one-cycle transfer acknowledge.
- CHNL_RX_LAST  in  1  host last-transfer flag; latched.
- CHNL_RX_LEN  in  32  transfer length in 32-bit words; latched.
- CHNL_RX_OFF  in  31  transfer offset; latched.
- CHNL_RX_DATA  in  64  receive data.
- CHNL_RX_DATA_VALID  in  1  data valid.
- CHNL_RX_DATA_REN  out  1  data read enable; beat transfers when VALID&REN.
- M_DATA  out  64  downstream data (registered).
- M_VALID  out  1  downstream valid.
- M_READY  in  1  downstream ready.
- M_LAST  out  1  marks beat index exp_beats-1.
- RX_LEN_Q  out  32  latched LEN.
- RX_OFF_Q  out  31  latched OFF.
- RX_LAST_Q  out  1  latched LAST.
- RX_BUSY  out  1  high in any state except IDLE.
- RX_DONE  out  1  one-cycle completion pulse.
- RX_WORDS  out  32  32-bit words received; valid with RX_DONE, held until next transaction.
- RX_SHORT  out  1  transfer ended before exp_beats; valid with RX_DONE.
- RX_TIMEOUT  out  1  abort flag; tied 0 without the macro.

Behaviour:
- Reset: state IDLE. All outputs 0, counters 0, output register empty. A reset mid-transaction discards the buffered beat with no RX_DONE.
- exp_beats = (LEN+1)>>1, computed in 33 bits and then truncated to CNT_W. An odd LEN makes the upper half of the final beat don't-care.
- IDLE: when CHNL_RX=1, latch LEN/OFF/LAST, clear beat_cnt, go to ACK.
- ACK: CHNL_RX_ACK=1 for exactly one cycle, then go to RECV.
- RECV:
  - REN = (beat_cnt<exp_beats) & (!M_VALID | M_READY). REN is combinational from state and registers only.
  - On VALID&REN: load M_DATA, set M_VALID, M_LAST=(beat_cnt==exp_beats-1), increment beat_cnt.
  - A beat is accepted into the register in the same cycle the previous beat drains (full throughput, latency 1).
  - Exit to DONE when (beat_cnt==exp_beats & CHNL_RX==0), or when (CHNL_RX==0 & VALID==0), which is the short case.
  - CHNL_RX still high after all beats: remain in RECV with REN=0.
- DONE:
  - Waits until the output register is empty (M_VALID=0, or M_VALID&M_READY this cycle).
  - Then pulses RX_DONE and sets RX_WORDS = min(2*beat_cnt, LEN). RX_SHORT = beat_cnt<exp_beats.
  - Go to IDLE.
- LEN=0: ACK, then RECV; REN is never asserted. DONE follows once CHNL_RX=0, with RX_WORDS=0, RX_SHORT=0 and no M_VALID.
- CHNL_RX high again during DONE: not acknowledged until IDLE. The next ACK comes no earlier than 2 cycles after RX_DONE.
- M_VALID holds, and M_DATA/M_LAST stay stable, until M_READY.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined:
  - In RECV, an idle counter increments each cycle without VALID&REN and clears on each accepted beat.
  - When it reaches TIMEOUT_CYCLES, go to DRAIN. DRAIN holds REN=1 and discards data until CHNL_RX=0 & VALID=0, then goes to DONE with RX_TIMEOUT=1.
- Not defined: no counter, no DRAIN state, RX_TIMEOUT=0. RECV waits indefinitely.

Decomposition:
- Package rx_ctrl_pkg: state encodings (IDLE, ACK, RECV, DRAIN, DONE), DATA_W=64, WORD_PER_BEAT_SHIFT=1.
- One sub-module, rx_out_reg: the 64-bit data + last, one-entry valid/ready register with load/accept logic.

Test Plan:
- LEN=8, VALID every cycle, M_READY=1:
  - ACK one cycle after CHNL_RX is sampled.
  - 4 beats with M_VALID, M_LAST on beat 3.
  - RX_DONE with RX_WORDS=8, RX_SHORT=0.
- LEN=7, M_READY toggling 1/0 each cycle:
  - REN=0 whenever the register is full and not draining.
  - 4 beats in order with no loss or duplication.
  - RX_WORDS=7.
- LEN=16, host drops CHNL_RX and VALID after 3 beats: RX_DONE with RX_SHORT=1, RX_WORDS=6, M_LAST never asserted.
- LEN=0: single ACK, no REN, no M_VALID; RX_DONE with RX_WORDS=0.
- RST asserted during beat 2 of a LEN=8 transfer:
  - Next cycle: all outputs 0, state IDLE, no RX_DONE.
  - A new CHNL_RX is acknowledged normally.
- With RX_TIMEOUT_EN, TIMEOUT_CYCLES=16, VALID stalled 16 cycles mid-transfer:
  - DRAIN with REN=1 until CHNL_RX=0.
  - Then RX_DONE with RX_TIMEOUT=1.

Source files
------------

// File: rtl/rx_ctrl_pkg.sv
// rtl/rx_ctrl_pkg.sv - shared types and constants for the RIFFA receive controller
//
// Purpose: controller state encoding and datapath constants used by rx_ctrl
//          and rx_out_reg.
// Ports:   none (package).
package rx_ctrl_pkg;

  localparam int DATA_W              = 64;
  // One 64-bit beat carries two 32-bit host words.
  localparam int WORD_PER_BEAT_SHIFT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_RECV  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rx_out_reg.sv
// rtl/rx_out_reg.sv - one-entry registered valid/ready output stage
//
// Purpose: holds one 64-bit beat plus its last flag toward downstream logic.
//          A new beat may be loaded in the same cycle the held beat drains.
// Ports:
//   CLK, RST          clock, synchronous active-high reset (empties the stage)
//   load              write load_data/load_last this cycle (only when can_load)
//   load_data/last    incoming beat and its last flag
//   ready             downstream ready
//   can_load          stage empty or draining this cycle
//   valid/data/last   registered downstream beat
module rx_out_reg
  import rx_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              can_load,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  assign can_load = !valid || ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_ctrl.sv
// rtl/rx_ctrl.sv - RIFFA channel receive-side controller
//
// Purpose: detects a host transfer on CHNL_RX, acknowledges it, pulls 64-bit
//          beats with CHNL_RX_DATA_REN and forwards them through a registered
//          valid/ready stage. Reports word count, short and timeout status.
// Optional feature: define RX_TIMEOUT_EN to abort a stalled RECV after
//          TIMEOUT_CYCLES idle cycles (DRAIN state discards remaining data).
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   CHNL_RX_CLK               forwarded CLK
//   CHNL_RX/_ACK              transfer request / one-cycle acknowledge
//   CHNL_RX_LAST/_LEN/_OFF    transfer attributes, latched in IDLE
//   CHNL_RX_DATA/_VALID/_REN  host data beat handshake
//   M_DATA/_VALID/_READY/_LAST  downstream stream
//   RX_LEN_Q/_OFF_Q/_LAST_Q   latched transfer attributes
//   RX_BUSY                   not IDLE
//   RX_DONE/_WORDS/_SHORT/_TIMEOUT  completion pulse and status
module rx_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              CHNL_RX_CLK,
  input  logic              CHNL_RX,
  output logic              CHNL_RX_ACK,
  input  logic              CHNL_RX_LAST,
  input  logic [31:0]       CHNL_RX_LEN,
  input  logic [30:0]       CHNL_RX_OFF,
  input  logic [DATA_W-1:0] CHNL_RX_DATA,
  input  logic              CHNL_RX_DATA_VALID,
  output logic              CHNL_RX_DATA_REN,
  output logic [DATA_W-1:0] M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_LAST,
  output logic [31:0]       RX_LEN_Q,
  output logic [30:0]       RX_OFF_Q,
  output logic              RX_LAST_Q,
  output logic              RX_BUSY,
  output logic              RX_DONE,
  output logic [31:0]       RX_WORDS,
  output logic              RX_SHORT,
  output logic              RX_TIMEOUT
);

  rx_state_t        state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] exp_beats;
  logic [32:0]      len_plus1;
  logic [CNT_W-1:0] exp_next;
  logic             can_load;
  logic             recv_ren;
  logic             beat_take;
  logic             done_ready;
  logic [63:0]      words_2x;

  assign CHNL_RX_CLK = CLK;
  assign RX_BUSY     = (state != ST_IDLE);

  // Round odd lengths up: the final beat then carries one valid word.
  assign len_plus1 = {1'b0, CHNL_RX_LEN} + 33'd1;
  assign exp_next  = CNT_W'(len_plus1 >> WORD_PER_BEAT_SHIFT);

  assign recv_ren  = (state == ST_RECV) && (beat_cnt < exp_beats) && can_load;
  assign beat_take = recv_ren && CHNL_RX_DATA_VALID;

  // Completion may be reported once the held beat leaves this cycle.
  assign done_ready = !M_VALID || M_READY;
  assign words_2x   = 64'(beat_cnt) << WORD_PER_BEAT_SHIFT;

`ifdef RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              timed_out;

  assign CHNL_RX_DATA_REN = recv_ren || (state == ST_DRAIN);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign CHNL_RX_DATA_REN   = recv_ren;
  assign RX_TIMEOUT         = 1'b0;
`endif

  rx_out_reg u_out (
    .CLK       (CLK),
    .RST       (RST),
    .load      (beat_take),
    .load_data (CHNL_RX_DATA),
    .load_last (beat_cnt == exp_beats - CNT_W'(1)),
    .ready     (M_READY),
    .can_load  (can_load),
    .valid     (M_VALID),
    .data      (M_DATA),
    .last      (M_LAST)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      CHNL_RX_ACK <= 1'b0;
      beat_cnt    <= '0;
      exp_beats   <= '0;
      RX_LEN_Q    <= '0;
      RX_OFF_Q    <= '0;
      RX_LAST_Q   <= 1'b0;
      RX_DONE     <= 1'b0;
      RX_WORDS    <= '0;
      RX_SHORT    <= 1'b0;
`ifdef RX_TIMEOUT_EN
      idle_cnt    <= '0;
      timed_out   <= 1'b0;
      RX_TIMEOUT  <= 1'b0;
`endif
    end else begin
      CHNL_RX_ACK <= 1'b0;
      RX_DONE     <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The cycle carrying RX_DONE is skipped so a waiting request is
          // acknowledged no sooner than two cycles after completion.
          if (CHNL_RX && !RX_DONE) begin
            RX_LEN_Q    <= CHNL_RX_LEN;
            RX_OFF_Q    <= CHNL_RX_OFF;
            RX_LAST_Q   <= CHNL_RX_LAST;
            exp_beats   <= exp_next;
            beat_cnt    <= '0;
            CHNL_RX_ACK <= 1'b1;
            state       <= ST_ACK;
`ifdef RX_TIMEOUT_EN
            idle_cnt    <= '0;
            timed_out   <= 1'b0;
`endif
          end
        end
        ST_ACK: state <= ST_RECV;
        ST_RECV: begin
          if (beat_take) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          // Neither exit condition can coincide with an accepted beat.
          if (!CHNL_RX && ((beat_cnt == exp_beats) || !CHNL_RX_DATA_VALID)) begin
            state <= ST_DONE;
          end
`ifdef RX_TIMEOUT_EN
          else if (beat_take) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            timed_out <= 1'b1;
            state     <= ST_DRAIN;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
`endif
        end
`ifdef RX_TIMEOUT_EN
        ST_DRAIN: begin
          if (!CHNL_RX && !CHNL_RX_DATA_VALID) begin
            state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (done_ready) begin
            RX_DONE  <= 1'b1;
            RX_WORDS <= (words_2x < 64'(RX_LEN_Q)) ? words_2x[31:0] : RX_LEN_Q;
            RX_SHORT <= (beat_cnt < exp_beats);
`ifdef RX_TIMEOUT_EN
            RX_TIMEOUT <= timed_out;
`endif
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ctrl.sv
// tb/tb_rx_ctrl.sv - self-checking bench for rx_ctrl
module tb_rx_ctrl;

  localparam int TO_CYC = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CHNL_RX_CLK;
  logic        CHNL_RX;
  logic        CHNL_RX_ACK;
  logic        CHNL_RX_LAST;
  logic [31:0] CHNL_RX_LEN;
  logic [30:0] CHNL_RX_OFF;
  logic [63:0] CHNL_RX_DATA;
  logic        CHNL_RX_DATA_VALID;
  logic        CHNL_RX_DATA_REN;
  logic [63:0] M_DATA;
  logic        M_VALID;
  logic        M_READY;
  logic        M_LAST;
  logic [31:0] RX_LEN_Q;
  logic [30:0] RX_OFF_Q;
  logic        RX_LAST_Q;
  logic        RX_BUSY;
  logic        RX_DONE;
  logic [31:0] RX_WORDS;
  logic        RX_SHORT;
  logic        RX_TIMEOUT;

  always #5 CLK = ~CLK;

  rx_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .CHNL_RX_CLK(CHNL_RX_CLK), .CHNL_RX(CHNL_RX),
    .CHNL_RX_ACK(CHNL_RX_ACK), .CHNL_RX_LAST(CHNL_RX_LAST), .CHNL_RX_LEN(CHNL_RX_LEN),
    .CHNL_RX_OFF(CHNL_RX_OFF), .CHNL_RX_DATA(CHNL_RX_DATA),
    .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID), .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .M_LAST(M_LAST),
    .RX_LEN_Q(RX_LEN_Q), .RX_OFF_Q(RX_OFF_Q), .RX_LAST_Q(RX_LAST_Q),
    .RX_BUSY(RX_BUSY), .RX_DONE(RX_DONE), .RX_WORDS(RX_WORDS),
    .RX_SHORT(RX_SHORT), .RX_TIMEOUT(RX_TIMEOUT)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Passive observer: downstream beats, handshake counts, completion status.
  logic [64:0] got_q[$];
  logic [63:0] sent_q[$];
  int          ack_cnt, ren_cnt, mv_cnt, done_cnt, ren_full_viol, hold_viol;
  logic [31:0] done_words;
  logic        done_short, done_to;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat;

  always @(negedge CLK) begin
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (CHNL_RX_ACK) ack_cnt++;
      if (CHNL_RX_DATA_REN) ren_cnt++;
      if (M_VALID) mv_cnt++;
      if (M_VALID && !M_READY && CHNL_RX_DATA_REN) ren_full_viol++;
      if (prev_stall && !(M_VALID && ({M_LAST, M_DATA} === prev_beat))) hold_viol++;
      prev_stall = M_VALID && !M_READY;
      prev_beat  = {M_LAST, M_DATA};
      if (M_VALID && M_READY) got_q.push_back({M_LAST, M_DATA});
      if (RX_DONE) begin
        done_cnt++;
        done_words = RX_WORDS;
        done_short = RX_SHORT;
        done_to    = RX_TIMEOUT;
      end
    end
  end

  task automatic clear_mon();
    got_q.delete();
    sent_q.delete();
    ack_cnt = 0; ren_cnt = 0; mv_cnt = 0; done_cnt = 0;
    ren_full_viol = 0; hold_viol = 0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic step_ready(input int rmode);
    if (rmode == 0)      M_READY = 1'b1;
    else if (rmode == 1) M_READY = ~M_READY;
    else                 M_READY = 1'($urandom);
  endtask

  // Returns the number of falling edges until ACK is seen (20 = never).
  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!CHNL_RX_ACK && lat < 20);
  endtask

  task automatic wait_done(input string nm, input int rmode);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 300) begin
      step_ready(rmode);
      cycle();
      cyc++;
    end
    M_READY = 1'b1;
    repeat (4) cycle();
    chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  // Push n beats with VALID held high; sent beats are recorded in sent_q.
  task automatic feed(input string nm, input int n);
    int   nb = 0;
    int   cyc = 0;
    logic xfer;
    while (nb < n && cyc < 100) begin
      CHNL_RX_DATA_VALID = 1'b1;
      CHNL_RX_DATA = {$urandom, $urandom};
      @(negedge CLK);
      xfer = CHNL_RX_DATA_REN;
      if (xfer) begin
        sent_q.push_back(CHNL_RX_DATA);
        nb++;
      end
      cycle();
      cyc++;
    end
    chk({nm, "_fed"}, 64'(nb), 64'(n));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_m_data"}, M_DATA, 64'd0);
    chk({nm, "_len_off_q"}, 64'({RX_LEN_Q, RX_OFF_Q}), 64'd0);
    chk({nm, "_words"}, 64'(RX_WORDS), 64'd0);
    chk({nm, "_flags"}, 64'({CHNL_RX_ACK, CHNL_RX_DATA_REN, M_VALID, M_LAST, RX_LAST_Q,
                             RX_BUSY, RX_DONE, RX_SHORT, RX_TIMEOUT}), 64'd0);
  endtask

  // Full transaction against the reference rules: exp_beats = ceil(len/2),
  // the host offers nsend beats (short when nsend < exp_beats) then drops
  // CHNL_RX and VALID together.
  task automatic run_txn(input string nm, input int len, input int nsend,
                         input int rmode, input int vpct);
    logic [63:0] hq[$];
    logic [63:0] sent[$];
    logic [30:0] off;
    logic        lst, xfer;
    int          expb, words, lat, cyc;
    expb  = (len + 1) / 2;
    words = (2 * nsend < len) ? 2 * nsend : len;
    for (int i = 0; i < nsend; i++) hq.push_back({$urandom, $urandom});
    sent = hq;
    off  = 31'($urandom);
    lst  = 1'($urandom);
    clear_mon();
    CHNL_RX = 1'b1; CHNL_RX_LEN = 32'(len); CHNL_RX_OFF = off; CHNL_RX_LAST = lst;
    wait_ack(lat);
    chk({nm, "_ack_lat"}, 64'(lat), 64'd2);
    chk({nm, "_len_q"}, 64'(RX_LEN_Q), 64'(len));
    chk({nm, "_off_last_q"}, 64'({RX_OFF_Q, RX_LAST_Q}), 64'({off, lst}));
    cycle();
    cyc = 0;
    while (hq.size() > 0 && cyc < 2000) begin
      CHNL_RX_DATA_VALID = ($urandom_range(99) < vpct);
      CHNL_RX_DATA = CHNL_RX_DATA_VALID ? hq[0] : {$urandom, $urandom};
      step_ready(rmode);
      @(negedge CLK);
      xfer = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
      cycle();
      if (xfer) void'(hq.pop_front());
      cyc++;
    end
    chk({nm, "_all_sent"}, 64'(hq.size()), 64'd0);
    CHNL_RX = 1'b0;
    CHNL_RX_DATA_VALID = 1'b0;
    wait_done(nm, rmode);
    chk({nm, "_words"}, 64'(done_words), 64'(words));
    chk({nm, "_short"}, 64'(done_short), 64'(nsend < expb));
    chk({nm, "_timeout"}, 64'(done_to), 64'd0);
    chk({nm, "_ack_cnt"}, 64'(ack_cnt), 64'd1);
    chk({nm, "_beats"}, 64'(got_q.size()), 64'(nsend));
    for (int i = 0; i < nsend && i < got_q.size(); i++) begin
      chk($sformatf("%s_data%0d", nm, i), got_q[i][63:0], sent[i]);
      chk($sformatf("%s_last%0d", nm, i), 64'(got_q[i][64]), 64'(i == expb - 1));
    end
    chk({nm, "_ren_when_full"}, 64'(ren_full_viol), 64'd0);
    chk({nm, "_hold"}, 64'(hold_viol), 64'd0);
    chk({nm, "_busy"}, 64'(RX_BUSY), 64'd0);
    if (len == 0) begin
      chk({nm, "_no_ren"}, 64'(ren_cnt), 64'd0);
      chk({nm, "_no_mvalid"}, 64'(mv_cnt), 64'd0);
    end
  endtask

  initial begin
    int lat;
    logic [63:0] d;
    RST = 1'b1; CHNL_RX = 1'b0; CHNL_RX_LAST = 1'b0; CHNL_RX_LEN = '0; CHNL_RX_OFF = '0;
    CHNL_RX_DATA = '0; CHNL_RX_DATA_VALID = 1'b0; M_READY = 1'b1;
    clear_mon();
    repeat (3) cycle();
    @(negedge CLK);
    chk_zero("reset");
    cycle();
    RST = 1'b0;
    repeat (2) cycle();

    run_txn("len8", 8, 4, 0, 100);
    run_txn("len7_tog", 7, 4, 1, 100);
    run_txn("len16_short", 16, 3, 0, 100);
    run_txn("len0", 0, 0, 0, 100);

    // Reset while the third beat of a LEN=8 transfer is on the bus.
    clear_mon();
    M_READY = 1'b1;
    CHNL_RX = 1'b1; CHNL_RX_LEN = 32'd8; CHNL_RX_OFF = 31'h1234; CHNL_RX_LAST = 1'b1;
    wait_ack(lat);
    chk("midrst_ack_lat", 64'(lat), 64'd2);
    cycle();
    feed("midrst", 2);
    RST = 1'b1;
    CHNL_RX = 1'b0;
    cycle();
    RST = 1'b0;
    CHNL_RX_DATA_VALID = 1'b0;
    @(negedge CLK);
    chk_zero("midrst");
    repeat (6) cycle();
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    run_txn("after_rst", 8, 4, 0, 100);

    // A request arriving while DONE waits on a full output stage.
    clear_mon();
    M_READY = 1'b0;
    CHNL_RX = 1'b1; CHNL_RX_LEN = 32'd2; CHNL_RX_OFF = '0; CHNL_RX_LAST = 1'b0;
    wait_ack(lat);
    cycle();
    feed("b2b", 1);
    d = (sent_q.size() > 0) ? sent_q[0] : 64'd0;
    CHNL_RX_DATA_VALID = 1'b0;
    CHNL_RX = 1'b0;
    repeat (2) cycle();
    CHNL_RX = 1'b1; CHNL_RX_LEN = 32'd0;
    repeat (5) cycle();
    chk("b2b_no_early_ack", 64'(ack_cnt), 64'd1);
    chk("b2b_no_early_done", 64'(done_cnt), 64'd0);
    chk("b2b_held_beat", {63'd0, M_VALID}, 64'd1);
    chk("b2b_held_data", M_DATA, d);
    M_READY = 1'b1;
    lat = 0;
    while (!RX_DONE && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk("b2b_done_seen", 64'(RX_DONE), 64'd1);
    wait_ack(lat);
    chk("b2b_ack_after_done", 64'(lat), 64'd2);
    chk("b2b_words", 64'(done_words), 64'd2);
    chk("b2b_short", 64'(done_short), 64'd0);
    chk("b2b_beat", (got_q.size() > 0) ? got_q[0] : 65'h1_dead_beef, {1'b1, d});
    clear_mon();
    CHNL_RX = 1'b0;
    cycle();
    wait_done("b2b_len0", 0);
    chk("b2b_len0_words", 64'(done_words), 64'd0);

    for (int t = 0; t < 6; t++) begin
      int len, expb, ns;
      len  = $urandom_range(40, 1);
      expb = (len + 1) / 2;
      ns   = ($urandom_range(3) == 0) ? int'($urandom_range(expb - 1, 0)) : expb;
`ifdef RX_TIMEOUT_EN
      run_txn($sformatf("rnd%0d", t), len, ns, 2, 100);
`else
      run_txn($sformatf("rnd%0d", t), len, ns, 2, int'($urandom_range(100, 40)));
`endif
    end

`ifdef RX_TIMEOUT_EN
    // Stall after 3 of 8 beats; the controller must abort and drain.
    clear_mon();
    M_READY = 1'b1;
    CHNL_RX = 1'b1; CHNL_RX_LEN = 32'd16; CHNL_RX_OFF = '0; CHNL_RX_LAST = 1'b0;
    wait_ack(lat);
    cycle();
    feed("to", 3);
    CHNL_RX_DATA_VALID = 1'b0;
    repeat (TO_CYC + 4) cycle();
    for (int i = 0; i < 4; i++) begin
      CHNL_RX_DATA_VALID = 1'b1;
      CHNL_RX_DATA = {$urandom, $urandom};
      @(negedge CLK);
      chk($sformatf("to_drain_ren%0d", i), 64'(CHNL_RX_DATA_REN), 64'd1);
      cycle();
    end
    CHNL_RX_DATA_VALID = 1'b0;
    CHNL_RX = 1'b0;
    wait_done("to", 0);
    chk("to_flag", 64'(done_to), 64'd1);
    chk("to_short", 64'(done_short), 64'd1);
    chk("to_words", 64'(done_words), 64'd6);
    chk("to_beats", 64'(got_q.size()), 64'd3);
`else
    chk("no_timeout_flag", 64'(RX_TIMEOUT), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
